snn_weight_store: RTL and testbench

- Q1.14 synaptic weight memory of F*N words, addressed addr = f*N + n (feature-major).
- Responder end of the neuron core's STDP write-back interface: accepts wb_we/wb_addr/wb_wdata, returns wb_rdata.
- Serves the core's per-step weight reads on a dedicated read port.
- Loaded at start-up from a valid/ready word stream; replaces testbench hierarchical ROM writes.

---
 rtl/snn_weight_store.sv | 192 +++++++++++++++++++
 tb/tb_snn_weight_store.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_weight_store.sv
// snn_weight_store: Q1.14 synaptic weight memory with a stream loader
// and an in-order, clamping STDP write-back queue.
module snn_weight_store #(
    parameter int F          = 48,
    parameter int N          = 96,
    parameter int AW         = (F * N <= 1) ? 1 : $clog2(F * N),
    parameter int FIFO_DEPTH = 4,
    parameter int W_MIN      = -32768,
    parameter int W_MAX      = 32767
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [15:0]   ld_data,
    output logic          ld_ready,
    output logic          ld_done,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [15:0]   rd_data,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_addr,
    input  logic [15:0]   wb_wdata,
    output logic [15:0]   wb_rdata,
    output logic          wb_full,
    output logic [15:0]   drop_cnt,
    output logic          running
);
    localparam int WORDS = F * N;
    localparam int PW    = (FIFO_DEPTH <= 1) ? 1 : $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] ld_cnt_q, ld_cnt_d;
    logic          ld_done_q, ld_done_d;
    logic [15:0]   drop_q, drop_d;
    logic [15:0]   rd_data_q, rd_data_d;
    logic [15:0]   wb_rdata_q, wb_rdata_d;
    logic [PW-1:0] rp_q, rp_d, wp_q, wp_d;
    logic [PW:0]   cnt_q, cnt_d;

    logic [AW-1:0] fa_q [FIFO_DEPTH];
    logic [15:0]   fd_q [FIFO_DEPTH];
    logic [15:0]   mem  [WORDS];

    logic          load_beat, flush, accept, push, pop;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [15:0]   mem_wdata;
    logic          fwd_hit;
    logic [15:0]   fwd_data;
    logic [PW-1:0] idx;

    function automatic logic in_range(input logic [AW-1:0] a);
        return int'(a) < WORDS;
    endfunction

    function automatic logic [15:0] clamp(input logic [15:0] v);
        int s;
        s = int'($signed(v));
        if (s < W_MIN) return 16'(W_MIN);
        if (s > W_MAX) return 16'(W_MAX);
        return v;
    endfunction

    assign ld_ready = (state_q == LOAD);
    assign running  = (state_q == RUN);
    assign ld_done  = ld_done_q;
    assign drop_cnt = drop_q;
    assign rd_data  = rd_data_q;
    assign wb_rdata = wb_rdata_q;
    assign wb_full  = (cnt_q == (PW+1)'(FIFO_DEPTH));

    always_comb begin
        state_d   = state_q;
        ld_cnt_d  = ld_cnt_q;
        ld_done_d = 1'b0;
        load_beat = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ld_start) begin
                    state_d  = LOAD;
                    ld_cnt_d = '0;
                end
            end
            LOAD: begin
                if (ld_start) begin
                    ld_cnt_d = '0;
                end else if (ld_valid) begin
                    load_beat = 1'b1;
                    if (ld_cnt_q == AW'(WORDS - 1)) begin
                        state_d   = RUN;
                        ld_done_d = 1'b1;
                        ld_cnt_d  = '0;
                    end else begin
                        ld_cnt_d = ld_cnt_q + 1'b1;
                    end
                end
            end
            RUN: begin
                if (ld_start) begin
                    state_d  = LOAD;
                    ld_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A pop never frees space for a same-cycle push: full is the registered count.
    always_comb begin
        flush  = ld_start;
        accept = wb_we && (state_q == RUN) && in_range(wb_addr) && !wb_full;
        push   = accept && !flush;
        pop    = (state_q == RUN) && (cnt_q != '0) && !rd_en && !flush;
        drop_d = drop_q;
        if (wb_we && !accept && drop_q != 16'hFFFF) drop_d = drop_q + 1'b1;
        if (flush) begin
            rp_d  = '0;
            wp_d  = '0;
            cnt_d = '0;
        end else begin
            rp_d  = rp_q + PW'(pop);
            wp_d  = wp_q + PW'(push);
            cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_comb begin
        mem_we    = !rst && (load_beat || pop);
        mem_waddr = load_beat ? ld_cnt_q : fa_q[rp_q];
        mem_wdata = load_beat ? ld_data : fd_q[rp_q];
    end

    // Newest queued entry for wb_addr wins; entries are stored pre-clamped.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            idx = rp_q + PW'(i);
            if ((PW+1)'(i) < cnt_q && fa_q[idx] == wb_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = fd_q[idx];
            end
        end
    end

    always_comb begin
        rd_data_d = '0;
        if (mem_we && mem_waddr == rd_addr) rd_data_d = mem_wdata;
        else if (in_range(rd_addr)) rd_data_d = mem[rd_addr];
        wb_rdata_d = '0;
        if (fwd_hit) wb_rdata_d = fwd_data;
        else if (mem_we && mem_waddr == wb_addr) wb_rdata_d = mem_wdata;
        else if (in_range(wb_addr)) wb_rdata_d = mem[wb_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ld_cnt_q   <= '0;
            ld_done_q  <= 1'b0;
            drop_q     <= '0;
            rd_data_q  <= '0;
            wb_rdata_q <= '0;
            rp_q       <= '0;
            wp_q       <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ld_cnt_q   <= ld_cnt_d;
            ld_done_q  <= ld_done_d;
            drop_q     <= drop_d;
            rd_data_q  <= rd_data_d;
            wb_rdata_q <= wb_rdata_d;
            rp_q       <= rp_d;
            wp_q       <= wp_d;
            cnt_q      <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        if (push) begin
            fa_q[wp_q] <= wb_addr;
            fd_q[wp_q] <= clamp(wb_wdata);
        end
    end

endmodule

// File: tb/tb_snn_weight_store.sv
// Bench for snn_weight_store (F=2, N=3): directed scenarios plus random
// traffic, checked against a queue/array reference model.
module tb_snn_weight_store;
    localparam int WMIN = -16384;
    localparam int WMAX = 16383;

    logic        clk = 1'b0;
    logic        rst, ld_start, ld_valid, rd_en, wb_we;
    logic [15:0] ld_data, wb_wdata;
    logic [2:0]  rd_addr, wb_addr;
    logic        ld_ready, ld_done, wb_full, running;
    logic [15:0] rd_data, wb_rdata, drop_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [2:0]  a;
        logic [15:0] d;
    } ent_t;

    ent_t        q[$];
    logic [15:0] mm[6];
    bit          known[6];
    bit          m_load, m_run, m_done;
    int          m_idx;
    logic [15:0] m_drop;
    bit          e_rd_v, e_wb_v;
    logic [15:0] e_rd, e_wb;
    logic [15:0] d4, l0, l1;

    snn_weight_store #(
        .F(2), .N(3), .FIFO_DEPTH(4), .W_MIN(WMIN), .W_MAX(WMAX)
    ) dut (
        .clk(clk), .rst(rst),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(ld_ready), .ld_done(ld_done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_wdata(wb_wdata),
        .wb_rdata(wb_rdata), .wb_full(wb_full),
        .drop_cnt(drop_cnt), .running(running)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] clampv(input logic [15:0] d);
        int v;
        v = int'($signed(d));
        if (v < WMIN) return 16'(WMIN);
        if (v > WMAX) return 16'(WMAX);
        return d;
    endfunction

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Predict the effect of the coming edge, apply it, then compare.
    task automatic step();
        ent_t        fe;
        bit          fhit, acc;
        logic [15:0] fval;
        fhit = 0;
        fval = '0;
        foreach (q[i]) if (q[i].a == wb_addr) begin
            fhit = 1;
            fval = q[i].d;
        end
        acc = wb_we && m_run && (wb_addr < 3'd6) && (q.size() < 4);
        if (rst) begin
            m_run = 0; m_load = 0; m_idx = 0; m_done = 0;
            m_drop = '0;
            q.delete();
            e_rd_v = 1; e_rd = '0;
            e_wb_v = 1; e_wb = '0;
        end else begin
            m_done = 0;
            if (wb_we && !acc && m_drop != 16'hFFFF) m_drop++;
            if (ld_start) begin
                q.delete();
                m_load = 1; m_run = 0; m_idx = 0;
            end else if (m_load && ld_valid) begin
                mm[m_idx] = ld_data;
                known[m_idx] = 1;
                if (m_idx == 5) begin
                    m_load = 0; m_run = 1; m_done = 1; m_idx = 0;
                end else m_idx++;
            end else if (m_run) begin
                if (!rd_en && q.size() > 0) begin
                    fe = q.pop_front();
                    mm[fe.a] = fe.d;
                end
                if (acc) q.push_back('{a: wb_addr, d: clampv(wb_wdata)});
            end
            e_rd_v = 0; e_rd = '0;
            if (rd_addr < 3'd6) begin
                e_rd_v = known[rd_addr];
                e_rd = mm[rd_addr];
            end
            e_wb_v = 0; e_wb = '0;
            if (fhit) begin
                e_wb_v = 1; e_wb = fval;
            end else if (wb_addr < 3'd6) begin
                e_wb_v = known[wb_addr];
                e_wb = mm[wb_addr];
            end
        end
        @(posedge clk);
        #1;
        chk("ld_ready", 16'(ld_ready), 16'(m_load));
        chk("ld_done", 16'(ld_done), 16'(m_done));
        chk("running", 16'(running), 16'(m_run));
        chk("wb_full", 16'(wb_full), 16'(q.size() == 4));
        chk("drop_cnt", drop_cnt, m_drop);
        if (e_rd_v) chk("rd_data", rd_data, e_rd);
        if (e_wb_v) chk("wb_rdata", wb_rdata, e_wb);
    endtask

    initial begin
        rst = 1; ld_start = 0; ld_valid = 0; ld_data = '0;
        rd_en = 0; rd_addr = '0; wb_we = 0; wb_addr = '0; wb_wdata = '0;
        m_drop = '0; m_idx = 0; m_load = 0; m_run = 0; m_done = 0;
        d4 = '0; l0 = '0; l1 = '0;
        step();
        step();
        rst = 0;

        // write-back while idle is dropped
        wb_we = 1; wb_addr = 3'd2; wb_wdata = 16'($urandom);
        step();
        wb_we = 0;
        chk("idle_drop", drop_cnt, 16'd1);

        ld_start = 1;
        step();
        ld_start = 0;
        for (int a = 0; a < 6; a++) begin
            ld_valid = 1; ld_data = 16'(a * 256); rd_addr = 3'(a);
            step();
        end
        ld_valid = 0;
        chk("load_running", 16'(running), 16'd1);
        rd_en = 1;
        for (int a = 0; a < 6; a++) begin
            rd_addr = 3'(a); wb_addr = 3'(a);
            step();
            chk("load_word", rd_data, 16'(a * 256));
        end

        // backpressure: 5 writes to addr 1 with commits frozen
        wb_addr = 3'd1; rd_addr = 3'd1;
        for (int k = 0; k < 5; k++) begin
            wb_we = 1; wb_wdata = 16'($urandom_range(0, 16'h3FFF));
            if (k == 3) d4 = wb_wdata;
            step();
        end
        wb_we = 0;
        chk("bp_full", 16'(wb_full), 16'd1);
        chk("bp_drop", drop_cnt, 16'd2);
        chk("bp_fwd", wb_rdata, d4);
        rd_en = 0;
        for (int k = 0; k < 4; k++) step();
        chk("bp_commit", rd_data, d4);
        chk("bp_empty", 16'(wb_full), 16'd0);

        // forwarding while rd_en holds memory stable
        rd_en = 1; wb_we = 1; wb_addr = 3'd2; wb_wdata = 16'h1234;
        step();
        wb_we = 0; rd_addr = 3'd2;
        step();
        chk("fwd_wb", wb_rdata, 16'h1234);
        chk("fwd_rd", rd_data, 16'h0200);
        rd_en = 0;
        step();
        chk("fwd_commit", rd_data, 16'h1234);

        // clamp on both ends
        rd_en = 1; wb_we = 1; wb_addr = 3'd3; wb_wdata = 16'h7FFF;
        step();
        wb_we = 0;
        step();
        chk("clamp_hi_fwd", wb_rdata, 16'h3FFF);
        rd_en = 0; rd_addr = 3'd3;
        step();
        chk("clamp_hi_mem", rd_data, 16'h3FFF);
        rd_en = 1; wb_we = 1; wb_wdata = 16'h8000;
        step();
        wb_we = 0;
        step();
        chk("clamp_lo_fwd", wb_rdata, 16'hC000);
        rd_en = 0;
        step();
        chk("clamp_lo_mem", rd_data, 16'hC000);

        // out-of-range address in RUN
        wb_we = 1; wb_addr = 3'd6; wb_wdata = 16'($urandom);
        step();
        wb_we = 0;
        chk("oor_drop", drop_cnt, 16'd3);

        for (int k = 0; k < 300; k++) begin
            rd_en    = ($urandom_range(0, 2) == 0);
            wb_we    = ($urandom_range(0, 1) == 1);
            wb_addr  = 3'($urandom_range(0, 6));
            wb_wdata = 16'($urandom);
            rd_addr  = 3'($urandom_range(0, 5));
            step();
        end
        wb_we = 0; rd_en = 0;
        for (int k = 0; k < 5; k++) step();

        // reload from RUN discards pending entries
        rd_en = 1;
        for (int k = 0; k < 3; k++) begin
            wb_we = 1; wb_addr = (k == 1) ? 3'd5 : 3'd4;
            wb_wdata = 16'($urandom);
            step();
        end
        wb_we = 0; wb_addr = 3'd4; rd_addr = 3'd4;
        ld_start = 1;
        step();
        ld_start = 0; rd_en = 0;
        chk("flush_running", 16'(running), 16'd0);
        for (int a = 0; a < 2; a++) begin
            ld_valid = 1; ld_data = 16'($urandom);
            if (a == 0) l0 = ld_data; else l1 = ld_data;
            step();
        end
        ld_valid = 0;
        rst = 1;
        step();
        rst = 0;
        chk("rst_ready", 16'(ld_ready), 16'd0);
        for (int a = 0; a < 6; a++) begin
            rd_addr = 3'(a); wb_addr = 3'(5 - a);
            step();
            if (a == 0) chk("rst_keep0", rd_data, l0);
            if (a == 1) chk("rst_keep1", rd_data, l1);
        end

        // ld_start mid-load restarts at address 0
        ld_start = 1;
        step();
        ld_start = 0;
        for (int a = 0; a < 3; a++) begin
            ld_valid = 1; ld_data = 16'($urandom);
            step();
        end
        ld_valid = 0; ld_start = 1;
        step();
        ld_start = 0;
        for (int a = 0; a < 6; a++) begin
            ld_valid = 1; ld_data = 16'($urandom); rd_addr = 3'(a);
            step();
        end
        ld_valid = 0;
        for (int a = 0; a < 6; a++) begin
            rd_addr = 3'(a); wb_addr = 3'(a);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
